// File: rtl/chroma_pkg.sv
// Shared chroma-key definitions: pixel field layout, reader FSM states and
// pack/unpack helpers used by the background reader and the compositor.
package chroma_pkg;

    localparam int PIX_W  = 10;
    localparam int R_LSB  = 20;
    localparam int G_LSB  = 10;
    localparam int B_LSB  = 0;
    localparam int WORD_W = 3 * PIX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pixel_t;

    function automatic pixel_t unpack_pixel(input logic [WORD_W-1:0] word);
        pixel_t p;
        p.r = word[R_LSB +: PIX_W];
        p.g = word[G_LSB +: PIX_W];
        p.b = word[B_LSB +: PIX_W];
        return p;
    endfunction

    // Memory word layout: {2'b0, R, G, B}.
    function automatic logic [31:0] pack_pixel(input pixel_t p);
        return {2'b00, p.r, p.g, p.b};
    endfunction

endpackage

// File: rtl/chroma_bg_fifo.sv
// Synchronous pixel FIFO with occupancy count, flush, and same-cycle push/pop.
// A push into an empty FIFO becomes visible at the head on the following cycle.
module chroma_bg_fifo
    import chroma_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/chroma_bg_reader.sv
// Background pixel source: streams a stored frame from SDRAM over Avalon-MM into a FIFO.
// Optional CHROMA_BG_UNDERFLOW_HOLD_EN: on underflow repeat the last pixel instead of black.
module chroma_bg_reader
    import chroma_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              iCLK27,
    input  logic              iRST,
    input  logic              iFrameStart,
    input  logic              iPixReq,
    output logic [PIX_W-1:0]  oVGA_R,
    output logic [PIX_W-1:0]  oVGA_G,
    output logic [PIX_W-1:0]  oVGA_B,
    output logic              oPixValid,
    output logic              oUnderflow,
    output logic [ADDR_W-1:0] oAvmAddress,
    output logic              oAvmRead,
    input  logic              iAvmWaitrequest,
    input  logic [31:0]       iAvmReadData,
    input  logic              iAvmReadDataValid
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int IW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [IW-1:0]     issued;
    logic [CW-1:0]     pending;
    logic [CW-1:0]     pending_nxt;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic              accept;
    logic              last_read;
    logic              push;
    pixel_t            pix_out;
    logic              unused_bits;

    assign accept      = oAvmRead & ~iAvmWaitrequest;
    assign last_read   = (issued == IW'(FRAME_PIX - 1));
    assign pending_nxt = pending + CW'(accept) - CW'(iAvmReadDataValid);
    // Returns belonging to an abandoned frame are counted off and dropped.
    assign push        = iAvmReadDataValid & (discard == '0) & ~iFrameStart;
    assign unused_bits = ^{iAvmReadData[31:30], fifo_full};

    chroma_bg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (iCLK27),
        .rst       (iRST),
        .flush     (iFrameStart),
        .push      (push),
        .push_data (iAvmReadData[WORD_W-1:0]),
        .pop       (iPixReq),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge iCLK27) begin
        if (iRST) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        state_nxt = state;
        if (iFrameStart) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH:   if (accept && last_read) state_nxt = DRAIN;
                DRAIN:   if (pending == '0)       state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Outstanding reads reserve FIFO slots so returns can never overflow it.
    always_comb begin
        oAvmRead = (state == FETCH) && (({1'b0, fifo_count} + {1'b0, pending}) < DEPTH_LIM);
    end

    always_ff @(posedge iCLK27) begin
        if (iRST) begin
            addr    <= '0;
            issued  <= '0;
            pending <= '0;
            discard <= '0;
        end else begin
            pending <= pending_nxt;
            if (iFrameStart) begin
                addr    <= ADDR_W'(BASE_ADDR);
                issued  <= '0;
                discard <= pending_nxt;
            end else begin
                if (accept && !last_read) begin
                    addr   <= addr + ADDR_W'(4);
                    issued <= issued + IW'(1);
                end
                if (iAvmReadDataValid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge iCLK27) begin
        if (iRST) begin
            pix_out    <= '0;
            oPixValid  <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            oPixValid <= iPixReq;
            if (iFrameStart) oUnderflow <= 1'b0;
            if (iPixReq) begin
                if (!fifo_empty) begin
                    pix_out <= unpack_pixel(fifo_head);
                end else begin
                    oUnderflow <= 1'b1;
`ifdef CHROMA_BG_UNDERFLOW_HOLD_EN
                    pix_out <= pix_out;
`else
                    pix_out <= '0;
`endif
                end
            end
        end
    end

    assign oVGA_R      = pix_out.r;
    assign oVGA_G      = pix_out.g;
    assign oVGA_B      = pix_out.b;
    assign oAvmAddress = addr;

endmodule
